clock_period_monitor: RTL and testbench
=======================================

Name: clock_period_monitor

Overview:
- Receive-side checker for divided clocks produced in the acquisition clocking path, e.g. the ADC/SEEG sample clock.
- Samples an asynchronous slow clock with a free-running fast clock and measures its period, high time and low time in fast-clock cycles.
- Compares the measured period against the programmed divisor and reports lock, mismatch and loss-of-clock (timeout).
- Sits beside the divider output; feeds status registers and bring-up debug.

Parameters:
- CNT_W, 16: width of the period, high and low counters and outputs.
- SYNC_STAGES, 2: flip-flops in the input synchronizer (minimum 2).
- LOCK_COUNT, 4: consecutive in-tolerance periods required to assert locked.
- TOL, 0: allowed absolute difference, in cycles, between measured period and divisor.

Ports:
- clock_in, input, 1: fast reference clock; all logic is in this domain.
- rst, input, 1: synchronous, active-high reset.
- sample_in, input, 1: monitored clock, asynchronous to clock_in.
- divisor, input, 4: expected period in clock_in cycles; static while locked.
- period, output, CNT_W: last complete measured period.
- high_time, output, CNT_W: cycles the synced input was high in the last period.
- low_time, output, CNT_W: period minus high_time.
- meas_valid, output, 1: one-cycle pulse when period, high_time and low_time update.
- locked, output, 1: level; LOCK_COUNT consecutive matching periods seen.
- mismatch, output, 1: one-cycle pulse on an out-of-tolerance period.
- timeout, output, 1: one-cycle pulse when no rising edge arrives within 2^CNT_W-1 cycles.

Behaviour:
Reset:
- Decided: one clock, clock_in; reset rst is synchronous and active-high.
- On rst = 1 all outputs go to 0, the synchronizer and edge register clear, the FSM enters SEEK and all counters clear.
- rst mid-measurement discards the partial period; no meas_valid is produced for it.

Input path and edge detection:
- sample_in passes through SYNC_STAGES flops to give s, plus one delay flop s_d.
- rise = s & ~s_d; fall = ~s & s_d.
- Edge spacing is preserved, so a clean divide-by-D input measures exactly D.

FSM:
- SEEK: ignore the level and wait for rise, so the first partial period is discarded. On rise go to HIGH with pcnt = 1, hcnt = 1.
- HIGH: each cycle pcnt += 1. While s = 1, hcnt += 1. On fall go to LOW.
- LOW: each cycle pcnt += 1. On rise:
  - register period = pcnt, high_time = hcnt, low_time = pcnt - hcnt; assert meas_valid the next cycle, aligned with the new values;
  - restart with pcnt = 1, hcnt = 1 and go to HIGH.
- Counters saturate at 2^CNT_W-1. When pcnt reaches that value in HIGH or LOW:
  - pulse timeout, clear locked and the lock counter, and go to SEEK;
  - period, high_time and low_time keep their last values.

Lock logic (evaluated on each completed period):
- Match when |period - divisor| <= TOL, with divisor zero-extended to CNT_W.
- Match: lock counter increments and saturates at LOCK_COUNT. locked rises in the same cycle meas_valid shows the LOCK_COUNT-th matching period.
- Mismatch: pulse mismatch together with meas_valid, clear the lock counter, clear locked.
- divisor < 2: checking disabled. locked is forced to 0, mismatch never pulses, measurements continue.
- A divisor change while locked is not special-cased. The next mismatching period clears locked.

Latency:
- sample_in rising edge to meas_valid is SYNC_STAGES + 2 clock_in cycles.

Simultaneous events:
- rise and saturation in the same cycle: rise wins; the period is reported as 2^CNT_W-1 and no timeout pulses.

Test Plan:
- Drive sample_in as an ideal divide-by-6 clock (3 high, 3 low), divisor = 6, TOL = 0. Expect:
  - first meas_valid on the second rising edge;
  - period = 6, high_time = 3, low_time = 3;
  - locked = 1 on the 4th meas_valid; mismatch never pulses.
- Divide-by-5 (2 high, 3 low), divisor = 5 -> period = 5, high_time = 2, low_time = 3; locked after 4 periods.
- Lock at divisor = 6, then switch the stimulus to divide-by-8 -> next meas_valid shows period = 8 with a 1-cycle mismatch pulse and locked = 0. Set divisor = 8 -> relocks after 4 periods.
- CNT_W = 8, locked at divide-by-6, hold sample_in low -> timeout pulses exactly once, locked = 0, period stays 6. Restart the clock -> first rising edge is discarded (SEEK), then normal measurement.
- Assert rst for 1 cycle in the middle of a HIGH phase -> all outputs 0 the next cycle; no meas_valid until two further rising edges; lock restarts from 0.
- divisor = 1 with a divide-by-4 stimulus -> period = 4 reported every period; locked stays 0; mismatch never pulses.

Source files
------------

// File: rtl/clock_period_monitor.sv
// Measures period, high time and low time of an asynchronous divided clock in
// clock_in cycles, and flags lock, mismatch and loss-of-clock against a divisor.
//
// state | meaning
// SEEK  | waiting for the first valid rising edge; the partial period is dropped
// HIGH  | counting a period, synced input high since the last rising edge
// LOW   | counting a period, synced input low; next rising edge completes it
module clock_period_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 0
) (
  input  logic             clock_in,
  input  logic             rst,
  input  logic             sample_in,
  input  logic [3:0]       divisor,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               LC_W    = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {SEEK, HIGH, LOW} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES:0]   r_vld;
  logic                   r_s_d;
  logic                   r_rise;
  logic                   r_fall;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_pcnt;
  logic [CNT_W-1:0]       r_hcnt;
  logic [LC_W-1:0]        r_lcnt;

  logic                   w_s;
  logic [CNT_W-1:0]       w_div;
  logic [CNT_W-1:0]       w_diff;
  logic                   w_match;
  logic                   w_chk_en;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_div    = CNT_W'(divisor);
  assign w_diff   = (r_pcnt >= w_div) ? (r_pcnt - w_div) : (w_div - r_pcnt);
  assign w_match  = (w_diff <= CNT_W'(TOL));
  assign w_chk_en = (divisor > 4'd1);

  // r_vld tracks which pipeline flops hold real samples since reset, so the
  // cleared synchronizer cannot fake a rising edge while sample_in is high.
  always_ff @(posedge clock_in) begin
    if (rst) begin
      r_sync <= '0;
      r_vld  <= '0;
      r_s_d  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sample_in};
      r_vld  <= {r_vld[SYNC_STAGES-1:0], 1'b1};
      r_s_d  <= w_s;
      r_rise <= r_vld[SYNC_STAGES] & w_s & ~r_s_d;
      r_fall <= r_vld[SYNC_STAGES] & ~w_s & r_s_d;
    end
  end

  // r_s_d is the level aligned with r_rise / r_fall.
  always_ff @(posedge clock_in) begin
    if (rst) begin
      r_state    <= SEEK;
      r_pcnt     <= '0;
      r_hcnt     <= '0;
      r_lcnt     <= '0;
      period     <= '0;
      high_time  <= '0;
      low_time   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      mismatch   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      mismatch   <= 1'b0;
      timeout    <= 1'b0;
      if (!w_chk_en) begin
        locked <= 1'b0;
        r_lcnt <= '0;
      end
      case (r_state)
        SEEK: begin
          if (r_rise) begin
            r_pcnt  <= CNT_W'(1);
            r_hcnt  <= CNT_W'(1);
            r_state <= HIGH;
          end
        end
        HIGH: begin
          if (r_pcnt == CNT_MAX) begin
            timeout <= 1'b1;
            locked  <= 1'b0;
            r_lcnt  <= '0;
            r_state <= SEEK;
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
            if (r_s_d) r_hcnt <= r_hcnt + 1'b1;
            if (r_fall) r_state <= LOW;
          end
        end
        LOW: begin
          // A rise on the saturating cycle still completes the period.
          if (r_rise) begin
            period     <= r_pcnt;
            high_time  <= r_hcnt;
            low_time   <= r_pcnt - r_hcnt;
            meas_valid <= 1'b1;
            r_pcnt     <= CNT_W'(1);
            r_hcnt     <= CNT_W'(1);
            r_state    <= HIGH;
            if (w_chk_en) begin
              if (w_match) begin
                if (r_lcnt < LC_W'(LOCK_COUNT)) r_lcnt <= r_lcnt + 1'b1;
                locked <= (r_lcnt >= LC_W'(LOCK_COUNT - 1));
              end else begin
                r_lcnt   <= '0;
                locked   <= 1'b0;
                mismatch <= 1'b1;
              end
            end
          end else if (r_pcnt == CNT_MAX) begin
            timeout <= 1'b1;
            locked  <= 1'b0;
            r_lcnt  <= '0;
            r_state <= SEEK;
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
          end
        end
        default: r_state <= SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_period_monitor.sv
// Bench for clock_period_monitor: drives sample_in as sequences of (high, low)
// periods and checks each measurement against a period-level reference model.
module tb_clock_period_monitor;

  localparam int CNT_W = 8;
  localparam int LOCK  = 4;
  localparam int TOL   = 0;
  localparam int MAXP  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_in;
  logic [3:0]       divisor;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] low_time;
  logic             meas_valid;
  logic             locked;
  logic             mismatch;
  logic             timeout;

  always #5 clk = ~clk;

  clock_period_monitor #(
    .CNT_W(CNT_W), .SYNC_STAGES(2), .LOCK_COUNT(LOCK), .TOL(TOL)
  ) dut (
    .clock_in  (clk),
    .rst       (rst),
    .sample_in (sample_in),
    .divisor   (divisor),
    .period    (period),
    .high_time (high_time),
    .low_time  (low_time),
    .meas_valid(meas_valid),
    .locked    (locked),
    .mismatch  (mismatch),
    .timeout   (timeout)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int per;
    int hi;
    int lo;
    int mis;
    int lck;
  } meas_t;

  meas_t exp_q[$];
  meas_t mon_e;
  bit    armed    = 1'b0;
  int    prev_h   = 0;
  int    prev_l   = 0;
  int    lock_cnt = 0;
  int    exp_to   = 0;
  int    seen_to  = 0;

  // A rising edge of the stimulus completes the previous period, if one was
  // being timed; a period longer than the counter range is lost to timeout.
  function automatic void model_rise(input int h, input int l);
    meas_t m;
    int    d;
    int    diff;
    d = int'(divisor);
    if (armed) begin
      m.hi  = prev_h;
      m.lo  = prev_l;
      m.per = prev_h + prev_l;
      diff  = (m.per > d) ? m.per - d : d - m.per;
      if (d < 2) begin
        m.mis = 0; m.lck = 0; lock_cnt = 0;
      end else if (diff <= TOL) begin
        if (lock_cnt < LOCK) lock_cnt++;
        m.mis = 0; m.lck = (lock_cnt == LOCK) ? 1 : 0;
      end else begin
        lock_cnt = 0; m.mis = 1; m.lck = 0;
      end
      exp_q.push_back(m);
    end
    armed  = 1'b1;
    prev_h = h;
    prev_l = l;
    if (h + l > MAXP) begin
      exp_to++;
      armed    = 1'b0;
      lock_cnt = 0;
    end
  endfunction

  task automatic drive_period(input int h, input int l);
    model_rise(h, l);
    sample_in = 1'b1;
    repeat (h) @(negedge clk);
    sample_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_high"}, int'(high_time), 0);
    chk({tag, "_low"}, int'(low_time), 0);
    chk({tag, "_valid"}, int'(meas_valid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_mismatch"}, int'(mismatch), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
  endtask

  task automatic reset_mid_high();
    model_rise(6, 3);
    sample_in = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("rst_mid");
    armed    = 1'b0;
    lock_cnt = 0;
    @(negedge clk);
    sample_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (timeout) seen_to++;
    if (mismatch && !meas_valid) chk("mismatch_without_valid", 1, 0);
    if (meas_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_meas_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("period", int'(period), mon_e.per);
        chk("high_time", int'(high_time), mon_e.hi);
        chk("low_time", int'(low_time), mon_e.lo);
        chk("mismatch", int'(mismatch), mon_e.mis);
        chk("locked", int'(locked), mon_e.lck);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, p, h;
    rst       = 1'b1;
    sample_in = 1'b0;
    divisor   = 4'd6;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    repeat (7) drive_period(3, 3);
    chk("locked_div6", int'(locked), 1);

    divisor = 4'd5;
    repeat (6) drive_period(2, 3);
    chk("locked_div5", int'(locked), 1);

    divisor = 4'd6;
    repeat (6) drive_period(3, 3);
    repeat (3) drive_period(4, 4);
    chk("unlocked_after_div8", int'(locked), 0);
    divisor = 4'd8;
    repeat (6) drive_period(4, 4);

    divisor = 4'd6;
    drive_period(5, MAXP - 5);
    drive_period(3, 3);
    chk("no_timeout_at_max_period", seen_to, exp_to);

    repeat (6) drive_period(3, 3);
    drive_period(3, 300);
    chk("timeout_count", seen_to, exp_to);
    chk("locked_after_timeout", int'(locked), 0);
    chk("period_held_after_timeout", int'(period), 6);
    repeat (6) drive_period(3, 3);

    reset_mid_high();
    repeat (6) drive_period(3, 3);

    divisor = 4'd1;
    repeat (6) drive_period(2, 2);
    chk("locked_disabled", int'(locked), 0);

    repeat (6) begin
      d = $urandom_range(4, 15);
      divisor = 4'(d);
      repeat (8) begin
        p = d;
        if ($urandom_range(0, 4) == 0) p = d + $urandom_range(0, 4) - 2;
        if (p < 4) p = 4;
        h = $urandom_range(1, p - 1);
        drive_period(h, p - h);
      end
    end

    repeat (8) @(negedge clk);
    chk("pending_measurements", exp_q.size(), 0);
    chk("timeout_total", seen_to, exp_to);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
